element_table_ctrl: RTL
=======================

ELEMENT_TABLE_CTRL -- requirements
Module: element_table_ctrl

Interface
REQ-001 Parameter NUM_ELEM, default 8: number of element slots; legal IDs are 0..NUM_ELEM-1.
REQ-002 Parameter FIFO_DEPTH, default 4: depth of the packet buffer, power of two.
REQ-003 clk50  input  1  system clock; the block has one clock, and all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 packet  input  40  UART packet: [39:32] elementID, [31:16] x_pos, [15:0] y_pos.
REQ-006 dataReceived  input  1  one-cycle strobe; packet is valid in that cycle.
REQ-007 rd_req  input  1  display read request.
REQ-008 rd_id  input  $clog2(NUM_ELEM)  slot to read.
REQ-009 rd_ready  output  1  read accepted this cycle; combinational.
REQ-010 rd_valid  output  1  read data valid; registered.
REQ-011 rd_x, rd_y  output  16 each  slot position.
REQ-012 rd_active  output  1  slot has been written since its last clear.
REQ-013 clr_ovf  input  1  clears the overflow flag.
REQ-014 overflow  output  1  sticky flag: a packet was dropped.
REQ-015 ign_cnt  output  8  count of packets discarded for an out-of-range ID.

Function
REQ-016 Push: on dataReceived, packet enters the FIFO; when full with no pop in that cycle, the packet is dropped and overflow is set.
REQ-017 Push and pop in the same cycle on a full FIFO shall both succeed, and no drop occurs.
REQ-018 FSM states: IDLE, WRITE, CLEAR.
- IDLE -> WRITE when the FIFO is non-empty.
- WRITE pops the head when granted; WRITE -> IDLE when the FIFO becomes empty.
REQ-019 Head with ID < NUM_ELEM: pop writes x, y and sets active=1 for that slot.
REQ-020 Head with ID 8'hFF: pop enters CLEAR.
- CLEAR clears every active flag in one cycle, then returns to WRITE or IDLE.
- x and y are unchanged.
REQ-021 Any other head ID is popped without a table change, and ign_cnt increments, saturating at 255.
REQ-022 Arbitration:
- Reads have priority: rd_ready=1 except on forced-write cycles.
- A pop occurs only in cycles with no accepted read.
REQ-023 Starvation guard: after 4 consecutive cycles with the FIFO non-empty and pops blocked by reads, the next cycle is a forced write.
- Forced write: rd_ready=0, and the pop occurs.
- The block counter resets on any pop.
REQ-024 Read latency is 1:
- rd_req && rd_ready in cycle N gives rd_valid=1 in N+1, with the table contents of cycle N.
- rd_valid=0 otherwise.
- rd_x, rd_y, rd_active hold their last value when rd_valid=0.
REQ-025 The CLEAR cycle counts as a pop for arbitration.
REQ-026 clr_ovf takes precedence over a simultaneous drop.

Reset
REQ-027 Asynchronous reset sets:
- FSM to IDLE and the FIFO to empty.
- All x, y and active flags to 0.
- overflow, ign_cnt, the starvation counter, rd_valid, rd_x, rd_y and rd_active to 0.
REQ-028 Reset mid-WRITE or mid-CLEAR abandons the operation, and buffered packets are lost.

Structure
REQ-029 Shared package game_pkg holds:
- packet field offsets;
- CLEAR_ID = 8'hFF;
- STARVE_LIMIT = 4;
- the FSM state typedef.
REQ-030 Sub-module pkt_fifo is a 40-bit synchronous FIFO with push, pop, full and empty; the table and FSM live in element_table_ctrl.

Verification
REQ-031 Packet {01,0010,0020}, no reads -> after drain, read id 1 gives rd_valid next cycle with x=0x0010, y=0x0020, active=1.
REQ-032 Five strobes back-to-back while rd_req is held high -> 4 buffered, 5th dropped, overflow=1.
- Forced-write pops occur every 5th cycle, with rd_ready=0 on those cycles.
REQ-033 Packet ID 9 -> ign_cnt=1, table unchanged.
- 256 more ID-9 packets -> ign_cnt=255.
REQ-034 Write IDs 2 and 3, then ID FF -> reads of 2 and 3 give active=0, with x and y retained.
REQ-035 Assert rst_n low during WRITE with 3 packets queued -> all outputs 0 and the FIFO empty.
- After release, no stale write occurs.
REQ-036 Full FIFO with simultaneous push and pop -> no drop, overflow remains 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the element table: packet layout, special IDs and FSM states.
package game_pkg;

    localparam int unsigned PKT_W        = 40;
    localparam int unsigned ID_LSB       = 32;
    localparam int unsigned ID_W         = 8;
    localparam int unsigned X_LSB        = 16;
    localparam int unsigned Y_LSB        = 0;
    localparam int unsigned POS_W        = 16;

    localparam logic [7:0]  CLEAR_ID     = 8'hFF;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous packet FIFO; a push on a full FIFO is accepted when a pop happens in the same cycle.
module pkt_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/element_table_ctrl.sv
// Element position table fed by buffered UART packets, with a read port that has priority
// over table updates except when the starvation guard forces a write.
module element_table_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk50,
    input  logic                        rst_n,
    input  logic [PKT_W-1:0]            packet,
    input  logic                        dataReceived,
    input  logic                        rd_req,
    input  logic [$clog2(NUM_ELEM)-1:0] rd_id,
    output logic                        rd_ready,
    output logic                        rd_valid,
    output logic [POS_W-1:0]            rd_x,
    output logic [POS_W-1:0]            rd_y,
    output logic                        rd_active,
    input  logic                        clr_ovf,
    output logic                        overflow,
    output logic [7:0]                  ign_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_ELEM);
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

    state_e              state_q, state_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          ign_q, ign_d;

    logic [POS_W-1:0]    x_q [NUM_ELEM];
    logic [POS_W-1:0]    y_q [NUM_ELEM];
    logic [NUM_ELEM-1:0] active_q;

    logic                rd_valid_q;
    logic [POS_W-1:0]    rd_x_q, rd_y_q;
    logic                rd_active_q;

    logic [PKT_W-1:0]    head;
    logic                fifo_full, fifo_empty;
    logic [ID_W-1:0]     head_id;
    logic [POS_W-1:0]    head_x, head_y;
    logic [IDX_W-1:0]    head_slot;

    logic                force_c, pop_c, wr_en_c, ign_c, clear_c, rd_accept_c, drop_c;

    pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk50),
        .rst_n   (rst_n),
        .push_i  (dataReceived),
        .pop_i   (pop_c),
        .wdata_i (packet),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_id   = head[ID_LSB +: ID_W];
    assign head_x    = head[X_LSB +: POS_W];
    assign head_y    = head[Y_LSB +: POS_W];
    assign head_slot = head_id[IDX_W-1:0];

    assign force_c     = (state_q == ST_WRITE) && !fifo_empty && (starve_q >= SW'(STARVE_LIMIT));
    assign rd_ready    = !force_c;
    assign rd_accept_c = rd_req && rd_ready;
    assign drop_c      = dataReceived && fifo_full && !pop_c;

    // Next-state and pop decode; a pop happens only when no read is accepted.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        wr_en_c = 1'b0;
        ign_c   = 1'b0;
        clear_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (!rd_accept_c) begin
                    pop_c = 1'b1;
                    if (head_id == CLEAR_ID) begin
                        state_d = ST_CLEAR;
                    end else if (32'(head_id) < NUM_ELEM) begin
                        wr_en_c = 1'b1;
                    end else begin
                        ign_c = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                clear_c = 1'b1;
                state_d = fifo_empty ? ST_IDLE : ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Starvation counter, overflow flag and ignore counter updates.
    always_comb begin
        starve_d   = starve_q;
        overflow_d = overflow_q;
        ign_d      = ign_q;
        if (pop_c || clear_c || fifo_empty) begin
            starve_d = '0;
        end else if ((state_q == ST_WRITE) && rd_accept_c && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end else if (drop_c) begin
            overflow_d = 1'b1;
        end
        if (ign_c && (ign_q != 8'hFF)) begin
            ign_d = ign_q + 8'd1;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            overflow_q <= 1'b0;
            ign_q      <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            overflow_q <= overflow_d;
            ign_q      <= ign_d;
        end
    end

    // Element table; CLEAR drops only the active flags, positions are kept.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            active_q <= '0;
        end else begin
            if (wr_en_c) begin
                x_q[head_slot]      <= head_x;
                y_q[head_slot]      <= head_y;
                active_q[head_slot] <= 1'b1;
            end
            if (clear_c) begin
                active_q <= '0;
            end
        end
    end

    // Read port: one-cycle latency, data held while rd_valid is low.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_active_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept_c;
            if (rd_accept_c) begin
                rd_x_q      <= x_q[rd_id];
                rd_y_q      <= y_q[rd_id];
                rd_active_q <= active_q[rd_id];
            end
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign rd_active = rd_active_q;
    assign overflow  = overflow_q;
    assign ign_cnt   = ign_q;

endmodule
